// File: rtl/pll_reset_sequencer.sv
// Sequences the PLL reset and ordered per-subsystem resets from a free-running refclk.
// Lock is synchronized locally; lock loss or a software request re-asserts every stage together.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int STAGE_GAP_CYCLES    = 32,
  parameter int NUM_STAGES          = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  locked_in,
  input  logic                  sw_reset_req,
  output logic                  pll_rst,
  output logic [NUM_STAGES-1:0] stage_reset_n,
  output logic                  sys_ready,
  output logic [7:0]            lock_loss_count,
  output logic [2:0]            state
);

  localparam int REL_CYCLES = NUM_STAGES * STAGE_GAP_CYCLES;
  localparam int M1 = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int M2 = (LOCK_STABLE_CYCLES > REL_CYCLES) ? LOCK_STABLE_CYCLES : REL_CYCLES;
  localparam int MAXC = (M1 > M2) ? M1 : M2;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } st_t;

  st_t                  st;
  logic [1:0]           sync;
  logic                 lock_s;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_inc;
  logic [NUM_STAGES-1:0] rel_mask;

  assign lock_s  = sync[1];
  assign cnt_inc = cnt + 1'b1;
  assign state   = st;

  // Stage k is released once the time since RELEASE entry reaches k gaps.
  always_comb begin
    rel_mask = '0;
    for (int k = 0; k < NUM_STAGES; k++)
      rel_mask[k] = (int'(cnt_inc) >= k * STAGE_GAP_CYCLES);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync <= 2'b00;
    else          sync <= {sync[0], locked_in};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st              <= S_PLL_RST;
      cnt             <= '0;
      pll_rst         <= 1'b1;
      stage_reset_n   <= '0;
      sys_ready       <= 1'b0;
      lock_loss_count <= 8'd0;
    end else begin
      case (st)
        S_PLL_RST: begin
          if (cnt == CW'(PLL_RST_CYCLES - 1)) begin
            st      <= S_WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            st  <= S_STABLE;
            cnt <= '0;
          end else if (cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
            st      <= S_PLL_RST;
            cnt     <= '0;
            pll_rst <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_STABLE: begin
          if (!lock_s) begin
            st  <= S_WAIT_LOCK;
            cnt <= '0;
          end else if (sw_reset_req) begin
            cnt <= '0;
          end else if (cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
            st            <= S_RELEASE;
            cnt           <= '0;
            stage_reset_n <= NUM_STAGES'(1);
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_RELEASE, S_RUN: begin
          // Lock loss outranks a software request.
          if (!lock_s) begin
            st            <= S_PLL_RST;
            cnt           <= '0;
            pll_rst       <= 1'b1;
            stage_reset_n <= '0;
            sys_ready     <= 1'b0;
            if (lock_loss_count != 8'hFF) lock_loss_count <= lock_loss_count + 8'd1;
          end else if (sw_reset_req) begin
            st            <= S_STABLE;
            cnt           <= '0;
            stage_reset_n <= '0;
            sys_ready     <= 1'b0;
          end else if (st == S_RELEASE) begin
            if (cnt_inc == CW'(REL_CYCLES)) begin
              st            <= S_RUN;
              cnt           <= '0;
              stage_reset_n <= '1;
              sys_ready     <= 1'b1;
            end else begin
              cnt           <= cnt_inc;
              stage_reset_n <= rel_mask;
            end
          end
        end
        default: begin
          st            <= S_PLL_RST;
          cnt           <= '0;
          pll_rst       <= 1'b1;
          stage_reset_n <= '0;
          sys_ready     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Reset sequencer sitting directly downstream of the system PLL. It drives the PLL's active-high reset and watches the PLL's asynchronous `locked` output. It waits for lock to be stable, then releases a set of ordered per-subsystem active-low resets (SDRAM controller first, then interconnect, then CPU) and reports readiness. On lock loss or a software request it re-asserts all resets and re-sequences; on lock timeout it re-resets the PLL.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high per PLL reset attempt.
- `LOCK_TIMEOUT_CYCLES`, 65536: cycles to wait for lock before retrying the PLL reset.
- `LOCK_STABLE_CYCLES`, 1024: consecutive cycles of synchronized lock required before release.
- `STAGE_GAP_CYCLES`, 32: spacing between successive stage releases.
- `NUM_STAGES`, 3: number of sequenced reset outputs (range 1–8).

Ports:
- `clk`  in  1: free-running 50 MHz reference clock (same net as PLL refclk, never a PLL output).
- `reset_n`  in  1: asynchronous, active-low reset.
- `locked_in`  in  1: PLL locked, asynchronous to `clk`.
- `sw_reset_req`  in  1: synchronous level request to re-sequence stage resets.
- `pll_rst`  out  1: active-high reset to the PLL.
- `stage_reset_n`  out  NUM_STAGES: active-low stage resets; bit 0 is released first.
- `sys_ready`  out  1: high only in RUN.
- `lock_loss_count`  out  8: count of lock losses after first release, saturating.
- `state`  out  3: debug encoding of the current state.

## Operation
- `locked_in` passes through a 2-flop synchronizer (reset to 0) to produce `lock_s`. All decisions use `lock_s` only.
- One shared cycle counter. It clears on every state transition.
- State encodings: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4.
- PLL_RST: `pll_rst`=1. After `PLL_RST_CYCLES` cycles, go to WAIT_LOCK.
- WAIT_LOCK: `pll_rst`=0.
  - `lock_s`=1 → STABLE.
  - Counter reaches `LOCK_TIMEOUT_CYCLES` without lock → PLL_RST.
- STABLE: requires `lock_s`=1 for `LOCK_STABLE_CYCLES` consecutive cycles, then → RELEASE.
  - Any `lock_s`=0 → WAIT_LOCK, with the timeout restarted.
- RELEASE: `stage_reset_n[k]` goes to 1 at entry + k·`STAGE_GAP_CYCLES`. Bit 0 is visible in the first RELEASE cycle.
  - At entry + `NUM_STAGES`·`STAGE_GAP_CYCLES`, go to RUN with `sys_ready`=1.
- RUN: all stage resets released and `sys_ready`=1.
- Lock loss (`lock_s`=0) in RELEASE or RUN, on the same edge:
  - all `stage_reset_n` go to 0;
  - `sys_ready` goes to 0;
  - `lock_loss_count` increments, saturating at 255;
  - state → PLL_RST.
- `sw_reset_req`=1 in RELEASE or RUN:
  - all `stage_reset_n` go to 0 and `sys_ready` goes to 0;
  - state → STABLE (lock re-verified, then re-released);
  - the count is unchanged;
  - while it is held, state stays in STABLE with the counter cleared.
- `sw_reset_req` is ignored in PLL_RST, WAIT_LOCK and STABLE, except for the hold behaviour above.
- Lock loss and `sw_reset_req` in the same cycle: lock loss wins (count increments, state → PLL_RST).
- Once released, a stage is never re-released out of order. Any re-assertion always asserts all bits together.

## Timing
- While `reset_n`=0 (asynchronous), outputs are: `pll_rst`=1, `stage_reset_n`=0, `sys_ready`=0, `lock_loss_count`=0, `state`=PLL_RST, synchronizer and counter at 0.
- Outputs are registered. Release (deassertion) is synchronous to `clk`.
- Consumers on PLL output clocks re-synchronize deassertion locally.
- `locked_in` edge to `lock_s`: 2 cycles.
- `locked_in` fall to stage reset assertion in RUN: 3 rising edges.
- `reset_n` asserted mid-RELEASE or mid-RUN: all outputs take their reset values immediately. After `reset_n` rises, the sequence restarts from PLL_RST.

## Test plan
Bench parameters: `PLL_RST_CYCLES`=4, `LOCK_TIMEOUT_CYCLES`=32, `LOCK_STABLE_CYCLES`=8, `STAGE_GAP_CYCLES`=4, `NUM_STAGES`=3.
- Release `reset_n` with `locked_in`=0 held → `pll_rst` high 4 cycles then low 32 cycles, repeating with period 36. Stages stay 000 and `sys_ready`=0.
- Raise `locked_in` and hold → STABLE for 8 cycles, then `stage_reset_n` = 001 at RELEASE entry, 011 at +4, 111 at +8, and `sys_ready`=1 at +12.
- Drop `locked_in` for 3 cycles after 5 cycles in STABLE → return to WAIT_LOCK, a fresh 8-cycle stability window after re-lock, and no stage released early.
- Drop `locked_in` in RUN → stages 000 and `sys_ready`=0 on the 3rd edge, `lock_loss_count` 0→1, `pll_rst`=1. Run 300 lock-loss cycles → count saturates at 255.
- Pulse `sw_reset_req` in RUN → stages 000 next edge, `state`=2, re-release 8 cycles later, count unchanged. Assert it in the same cycle as `lock_s` falls → PLL_RST and count +1.
- Assert `reset_n`=0 while `stage_reset_n`=011 → outputs go to reset values without waiting for a `clk` edge.
